// File: rtl/db9md_pad_scanner.sv
// Scans two Mega Drive 3/6-button pads sharing one DB9 port and decodes them into active-high words.
// Latency: a pad's word commits on the last cycle of its step 7 and is visible one cycle later.
// Backpressure: none; free-running scan, outputs are held between commits.
//
// Optional feature: define DB9MD_DEBOUNCE_EN to require two identical consecutive scans before a
// word reaches the output.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   joy_in     raw pad lines, active-low: [0]U [1]D [2]L [3]R [4]B/A [5]C/Start
//   joy_mdsel  pad select (TH) line
//   joy_split  port mux: 0 = player 1 pad, 1 = player 2 pad
//   joystick1  player 1 buttons, active-high (0 R,1 L,2 D,3 U,4 B,5 C,6 A,7 Start,8 Mode,9 X,10 Y,11 Z)
//   joystick2  player 2 buttons, same map
//   frame_done one-cycle pulse when the player 2 word commits
module db9md_pad_scanner #(
  parameter int STEP_CYC = 400,
  parameter int IDLE_CYC = 64000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  joy_in,
  output logic        joy_mdsel,
  output logic        joy_split,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  localparam int MAX_CYC = (STEP_CYC > IDLE_CYC) ? STEP_CYC : IDLE_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYC - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_P1   = 2'd0,
    ST_P2   = 2'd1,
    ST_IDLE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   dec_q, dec_d;
  logic          present_q, present_d;
  logic          six_q, six_d;
  logic [15:0]   joy1_q, joy1_d;
  logic [15:0]   joy2_q, joy2_d;
  logic          done_q, done_d;
`ifdef DB9MD_DEBOUNCE_EN
  logic [15:0]   cand1_q, cand1_d;
  logic [15:0]   cand2_q, cand2_d;
`endif

  logic          in_pad;
  logic          step_end;
  logic          commit;
  logic [15:0]   word_w;

  assign in_pad   = (state_q != ST_IDLE);
  assign step_end = in_pad && (cnt_q == STEP_LAST);
  assign commit   = step_end && (step_q == 3'd7);

  // Absent pad reads as nothing pressed; a 3-button pad cannot report the extra buttons.
  always_comb begin
    word_w = 16'h0000;
    if (present_q) begin
      word_w[7:0] = dec_q[7:0];
      if (six_q) begin
        word_w[11:8] = dec_q[11:8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    dec_d     = dec_q;
    present_d = present_q;
    six_d     = six_q;
    joy1_d    = joy1_q;
    joy2_d    = joy2_q;
    done_d    = 1'b0;
`ifdef DB9MD_DEBOUNCE_EN
    cand1_d   = cand1_q;
    cand2_d   = cand2_q;
`endif

    // Sequencing: the count only wraps alongside a step or state change.
    if (in_pad) begin
      if (cnt_q == STEP_LAST) begin
        cnt_d = '0;
        if (step_q == 3'd7) begin
          step_d  = 3'd0;
          state_d = (state_q == ST_P1) ? ST_P2 : ST_IDLE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (cnt_q == IDLE_LAST) begin
        cnt_d   = '0;
        step_d  = 3'd0;
        state_d = ST_P1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Fresh decode state for every player so nothing leaks from P1 into P2.
    if (in_pad && (step_q == 3'd0) && (cnt_q == '0)) begin
      dec_d     = '0;
      present_d = 1'b0;
      six_d     = 1'b0;
    end

    // Lines are sampled at the end of a step, after they have settled behind the select edge.
    if (step_end) begin
      unique case (step_q)
        3'd0: begin
          dec_d[0] = ~joy_in[3];
          dec_d[1] = ~joy_in[2];
          dec_d[2] = ~joy_in[1];
          dec_d[3] = ~joy_in[0];
          dec_d[4] = ~joy_in[4];
          dec_d[5] = ~joy_in[5];
        end
        3'd1: begin
          present_d = (joy_in[1:0] == 2'b00);
          dec_d[6]  = ~joy_in[4];
          dec_d[7]  = ~joy_in[5];
        end
        3'd5: begin
          six_d = (joy_in[3:0] == 4'b0000);
        end
        3'd6: begin
          dec_d[11] = ~joy_in[0];
          dec_d[10] = ~joy_in[1];
          dec_d[9]  = ~joy_in[2];
          dec_d[8]  = ~joy_in[3];
        end
        default: begin
        end
      endcase
    end

    if (commit) begin
`ifdef DB9MD_DEBOUNCE_EN
      // Output moves only when two consecutive scans agree.
      if (state_q == ST_P1) begin
        if (word_w == cand1_q) joy1_d = word_w;
        cand1_d = word_w;
      end else begin
        if (word_w == cand2_q) joy2_d = word_w;
        cand2_d = word_w;
      end
`else
      if (state_q == ST_P1) begin
        joy1_d = word_w;
      end else begin
        joy2_d = word_w;
      end
`endif
      if (state_q == ST_P2) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_P1;
      step_q    <= 3'd0;
      cnt_q     <= '0;
      dec_q     <= '0;
      present_q <= 1'b0;
      six_q     <= 1'b0;
      joy1_q    <= '0;
      joy2_q    <= '0;
      done_q    <= 1'b0;
`ifdef DB9MD_DEBOUNCE_EN
      cand1_q   <= '0;
      cand2_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      dec_q     <= dec_d;
      present_q <= present_d;
      six_q     <= six_d;
      joy1_q    <= joy1_d;
      joy2_q    <= joy2_d;
      done_q    <= done_d;
`ifdef DB9MD_DEBOUNCE_EN
      cand1_q   <= cand1_d;
      cand2_q   <= cand2_d;
`endif
    end
  end

  // Select is high on even steps and throughout idle.
  assign joy_mdsel  = (state_q == ST_IDLE) || !step_q[0];
  assign joy_split  = (state_q == ST_P2);
  assign joystick1  = joy1_q;
  assign joystick2  = joy2_q;
  assign frame_done = done_q;

endmodule
